fp_mult_pipe: RTL and testbench

//  Pipelined IEEE-style floating-point multiplier with valid/ready handshake, parametrised in EXP_W/MANT_W.

---
 rtl/fp_mult_pkg.sv | 25 ++
 rtl/exp_adder.sv | 16 +
 rtl/fp_mult_norm_round.sv | 92 +++++++++
 rtl/fp_mult_pipe.sv | 137 +++++++++++++
 tb/tb_fp_mult_pipe.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fp_mult_pkg.sv
// Shared constants and helpers for the pipelined floating-point multiplier.
package fp_mult_pkg;

  localparam int unsigned FLG_NV = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  typedef enum logic [1:0] {
    SpNone,
    SpZero,
    SpInf,
    SpNan
  } special_e;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, 0..0}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan_word(input int unsigned exp_w, input int unsigned mant_w);
    return (((64'd1 << exp_w) - 64'd1) << (mant_w - 1)) | (64'd1 << (mant_w - 2));
  endfunction

endpackage

// File: rtl/exp_adder.sv
// Biased exponent sum: ea + eb - BIAS as a signed value with two guard bits.
module exp_adder
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W = 8
) (
  input  logic        [EXP_W-1:0] ea_i,
  input  logic        [EXP_W-1:0] eb_i,
  output logic signed [EXP_W+1:0] sum_o
);

  localparam logic [EXP_W+1:0] Bias = (EXP_W + 2)'(bias(EXP_W));

  assign sum_o = signed'({2'b00, ea_i} + {2'b00, eb_i} - Bias);

endmodule

// File: rtl/fp_mult_norm_round.sv
// Final-stage normalise, round, range check and special-case packing (combinational).
// Rounding is round-to-nearest-even when FP_MULT_RNE_EN is defined, truncation otherwise.
module fp_norm_round
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 24
) (
  input  logic                        sign_i,
  input  logic signed [EXP_W+1:0]     exp_i,
  input  logic        [2*MANT_W-1:0]  prod_i,
  input  special_e                    special_i,
  output logic        [EXP_W+MANT_W-1:0] res_o,
  output logic        [3:0]           flags_o
);

  localparam logic signed [EXP_W+1:0] ExpOne  = (EXP_W + 2)'(1);
  localparam logic signed [EXP_W+1:0] ExpZero = '0;
  localparam logic signed [EXP_W+1:0] ExpMax  = (EXP_W + 2)'((64'd1 << EXP_W) - 64'd1);
  localparam logic [EXP_W+MANT_W-1:0] QNaN    = (EXP_W + MANT_W)'(qnan_word(EXP_W, MANT_W));

  logic [MANT_W-1:0]       mant;
  logic [MANT_W:0]         mant_r;
  logic [MANT_W-2:0]       frac;
  logic                    guard, sticky, inc;
  logic signed [EXP_W+1:0] e_n, e_r;
  logic                    unused_hidden;

  assign unused_hidden = mant_r[MANT_W-1];

  always_comb begin
    if (prod_i[2*MANT_W-1]) begin
      mant   = prod_i[2*MANT_W-1 -: MANT_W];
      guard  = prod_i[MANT_W-1];
      sticky = |prod_i[MANT_W-2:0];
      e_n    = exp_i + ExpOne;
    end else begin
      mant   = prod_i[2*MANT_W-2 -: MANT_W];
      guard  = prod_i[MANT_W-2];
      sticky = |prod_i[MANT_W-3:0];
      e_n    = exp_i;
    end

`ifdef FP_MULT_RNE_EN
    inc = guard & (sticky | mant[0]);
`else
    inc = 1'b0;
`endif

    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // Carry out leaves 1.000..0 x 2, so the fraction is all zeros.
    if (mant_r[MANT_W]) begin
      frac = '0;
      e_r  = e_n + ExpOne;
    end else begin
      frac = mant_r[MANT_W-2:0];
      e_r  = e_n;
    end

    res_o           = {sign_i, e_r[EXP_W-1:0], frac};
    flags_o         = '0;
    flags_o[FLG_NX] = guard | sticky;

    if (e_r >= ExpMax) begin
      res_o           = {sign_i, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      flags_o[FLG_OF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end else if (e_r <= ExpZero) begin
      res_o           = {sign_i, {(EXP_W+MANT_W-1){1'b0}}};
      flags_o[FLG_UF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end

    case (special_i)
      SpNan: begin
        res_o           = QNaN;
        flags_o         = '0;
        flags_o[FLG_NV] = 1'b1;
      end
      SpInf: begin
        res_o   = {sign_i, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
        flags_o = '0;
      end
      SpZero: begin
        res_o   = {sign_i, {(EXP_W+MANT_W-1){1'b0}}};
        flags_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier (exponent add, mantissa product, normalise/round/pack)
// with a global-stall valid/ready handshake. Rounding mode selected by FP_MULT_RNE_EN.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] in_a,
  input  logic [EXP_W+MANT_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_res,
  output logic [3:0]              out_flags
);

  localparam int unsigned W = EXP_W + MANT_W;
  localparam int unsigned F = MANT_W - 1;

  logic adv;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [F-1:0]     fa, fb;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic signed [EXP_W+1:0] exp_sum;
  special_e                special_d;

  logic                    s1_valid_q, s1_sign_q;
  logic signed [EXP_W+1:0] s1_exp_q;
  logic [F-1:0]            s1_fa_q, s1_fb_q;
  special_e                s1_special_q;

  logic [2*MANT_W-1:0]     s2_prod_d, s2_prod_q;
  logic                    s2_valid_q, s2_sign_q;
  logic signed [EXP_W+1:0] s2_exp_q;
  special_e                s2_special_q;

  logic [W-1:0] res_d;
  logic [3:0]   flags_d;

  // Whole pipeline advances together; bubbles are carried, not squeezed.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign sa = in_a[W-1];
  assign sb = in_b[W-1];
  assign ea = in_a[W-2 -: EXP_W];
  assign eb = in_b[W-2 -: EXP_W];
  assign fa = in_a[F-1:0];
  assign fb = in_b[F-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~|fa;
  assign b_inf  = (&eb) & ~|fb;
  assign a_nan  = (&ea) & |fa;
  assign b_nan  = (&eb) & |fb;

  always_comb begin
    special_d = SpNone;
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
      special_d = SpNan;
    end else if (a_inf | b_inf) begin
      special_d = SpInf;
    end else if (a_zero | b_zero) begin
      special_d = SpZero;
    end
  end

  exp_adder #(
    .EXP_W(EXP_W)
  ) u_exp_adder (
    .ea_i (ea),
    .eb_i (eb),
    .sum_o(exp_sum)
  );

  always_comb begin
    s2_prod_d = '0;
    if (s1_special_q == SpNone) begin
      s2_prod_d = {{MANT_W{1'b0}}, 1'b1, s1_fa_q} * {{MANT_W{1'b0}}, 1'b1, s1_fb_q};
    end
  end

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MANT_W(MANT_W)
  ) u_norm_round (
    .sign_i   (s2_sign_q),
    .exp_i    (s2_exp_q),
    .prod_i   (s2_prod_q),
    .special_i(s2_special_q),
    .res_o    (res_d),
    .flags_o  (flags_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_fa_q      <= '0;
      s1_fb_q      <= '0;
      s1_special_q <= SpNone;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_prod_q    <= '0;
      s2_special_q <= SpNone;
      out_valid    <= 1'b0;
      out_res      <= '0;
      out_flags    <= '0;
    end else if (adv) begin
      s1_valid_q   <= in_valid;
      s1_sign_q    <= sa ^ sb;
      s1_exp_q     <= exp_sum;
      s1_fa_q      <= fa;
      s1_fb_q      <= fb;
      s1_special_q <= special_d;
      s2_valid_q   <= s1_valid_q;
      s2_sign_q    <= s1_sign_q;
      s2_exp_q     <= s1_exp_q;
      s2_prod_q    <= s2_prod_d;
      s2_special_q <= s1_special_q;
      out_valid    <= s2_valid_q;
      out_res      <= res_d;
      out_flags    <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe (binary32 defaults).
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

`ifdef FP_MULT_RNE_EN
  localparam logic [31:0] ExpRound = 32'h3FC0_0002;
`else
  localparam logic [31:0] ExpRound = 32'h3FC0_0001;
`endif

  logic [31:0] va [4] = '{32'h3FC0_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000};
  logic [31:0] vb [4] = '{32'h4000_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000};
  logic [31:0] vr [4] = '{32'h4040_0000, 32'h4080_0000, 32'hC040_0000, 32'h3E80_0000};

  fp_mult_pipe u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated op with out_ready=1: checks accept, 3-cycle latency, result and flags.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd3);
    check_eq({tag, "_res"}, 64'(out_res), 64'(exp_res));
    check_eq({tag, "_flg"}, 64'(out_flags), 64'(exp_flags));
    @(posedge clk);
    #1;
    check_eq({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int  got;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_res", 64'(out_res), 64'd0);
    check_eq("rst_flags", 64'(out_flags), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    run_op("basic", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000);
    run_op("round", 32'h3F80_0001, 32'h3FC0_0000, ExpRound, 4'b0001);
    run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101);
    run_op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011);
    run_op("infz", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
    run_op("ninf", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000);
    run_op("nzero", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000);
    run_op("nan", 32'h0000_0000, 32'h7FC0_0001, 32'h7FC0_0000, 4'b1000);

    // Back-to-back with downstream stalled: three ops fill the pipe, the fourth waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = va[i];
      in_b = vb[i];
      if (i < 3) @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_rdy", 64'(in_ready), 64'd0);
      check_eq("stall_vld", 64'(out_valid), 64'd1);
      check_eq("stall_res", 64'(out_res), 64'(vr[0]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      acc = in_valid & in_ready;
      if (out_valid) begin
        check_eq("drain_res", 64'(out_res), 64'(vr[got]));
        check_eq("drain_flg", 64'(out_flags), 64'd0);
        got++;
      end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    check_eq("drain_cnt", 64'(got), 64'd4);

    // Asynchronous reset while a result is held at the output.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h4000_0000;
    in_b      = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_vld", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_vld", 64'(out_valid), 64'd0);
    check_eq("arst_res", 64'(out_res), 64'd0);
    check_eq("arst_rdy", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    run_op("post_rst", 32'hBF80_0000, 32'h4040_0000, 32'hC040_0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
